// File: rtl/setting_display_pkg.sv
// Shared definitions for the settings display path.
// Holds the seven-segment glyphs (active-low {dp,g,f,e,d,c,b,a}), the
// decimal-point mask, the decoder's special codes and the page indices.
package setting_display_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Clearing this bit lights the decimal point.
  localparam logic [7:0] DP_MASK   = 8'h80;

  // Decoder codes beyond the decimal digits 0..9.
  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [2:0] PAGE_WELCOME   = 3'd0;
  localparam logic [2:0] PAGE_PLAYERS   = 3'd1;
  localparam logic [2:0] PAGE_QUESTIONS = 3'd2;
  localparam logic [2:0] PAGE_TIME      = 3'd3;
  localparam logic [2:0] PAGE_WIN       = 3'd4;
  localparam logic [2:0] PAGE_SUCCESS   = 3'd5;
  localparam logic [2:0] PAGE_FAIL      = 3'd6;

endpackage

// File: rtl/setting_display_if.sv
// Settings-to-display bus.
//   view/state        : top-level view and settings page
//   *_count/_time/... : the six setting values
//   seg_en/seg_out    : active-low digit enables and segments
// master = settings side, slave = display block.
interface setting_display_if;
  logic [2:0] view;
  logic [2:0] state;
  logic [2:0] player_count;
  logic [3:0] question_count;
  logic [6:0] answer_time;
  logic [6:0] win_score;
  logic [3:0] success_score;
  logic [3:0] fail_score;
  logic [7:0] seg_en;
  logic [7:0] seg_out;

  modport master (
    output view, state, player_count, question_count, answer_time,
           win_score, success_score, fail_score,
    input  seg_en, seg_out
  );

  modport slave (
    input  view, state, player_count, question_count, answer_time,
           win_score, success_score, fail_score,
    output seg_en, seg_out
  );
endinterface

// File: rtl/seg7_decoder.sv
// Seven-segment glyph decoder, shared by the display blocks.
//   code : 0..9 digit, CODE_DASH for '-', anything else blank
//   dp   : light the decimal point
//   seg  : active-low pattern {dp,g,f,e,d,c,b,a}
module seg7_decoder
  import setting_display_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    case (code)
      4'd0:      glyph = SEG_0;
      4'd1:      glyph = SEG_1;
      4'd2:      glyph = SEG_2;
      4'd3:      glyph = SEG_3;
      4'd4:      glyph = SEG_4;
      4'd5:      glyph = SEG_5;
      4'd6:      glyph = SEG_6;
      4'd7:      glyph = SEG_7;
      4'd8:      glyph = SEG_8;
      4'd9:      glyph = SEG_9;
      CODE_DASH: glyph = SEG_DASH;
      default:   glyph = SEG_BLANK;
    endcase
    seg = dp ? (glyph & ~DP_MASK) : glyph;
  end

endmodule

// File: rtl/setting_display.sv
// Settings-view driver for the 8-digit multiplexed seven-segment display.
//   clk, rst : system clock, synchronous active-high reset
//   disp     : slave side of setting_display_if (view, page, values in;
//              seg_en/seg_out out, both active-low and registered)
// Digit 7 shows the page number (blinking, dp lit); digits 1..0 show the
// selected value in decimal. Any view other than 0 blanks the display
// while the scan keeps running.
module setting_display
  import setting_display_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic               clk,
  input  logic               rst,
  setting_display_if.slave   disp
);

  localparam int DIV_W = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1;
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLINK_MAX = BLK_W'(BLINK_TICKS - 1);

  logic [DIV_W-1:0] div;
  logic [2:0]       idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             phase;
  logic [2:0]       state_q;
  logic [2:0]       view_q;

  logic       tick;
  logic       restart;
  logic       blink_on;
  logic [6:0] val;
  logic       two_digit;
  logic [3:0] code;
  logic       dp;
  logic [7:0] seg;

  assign tick    = (div == DIV_MAX);
  // Page change or re-entering the settings view restarts the blink with
  // the digit on; the forced-on phase also applies to a same-cycle scan.
  assign restart  = (disp.state != state_q) ||
                    ((disp.view == 3'd0) && (view_q != 3'd0));
  assign blink_on = restart || phase;

  always_comb begin
    val       = '0;
    two_digit = 1'b0;
    case (disp.state)
      PAGE_PLAYERS:   val = {4'd0, disp.player_count};
      PAGE_QUESTIONS: val = {3'd0, disp.question_count};
      PAGE_TIME:      begin val = disp.answer_time; two_digit = 1'b1; end
      PAGE_WIN:       begin val = disp.win_score;   two_digit = 1'b1; end
      PAGE_SUCCESS:   val = {3'd0, disp.success_score};
      PAGE_FAIL:      val = {3'd0, disp.fail_score};
      default:        ;
    endcase
  end

  // Digit content for the digit about to be scanned.
  always_comb begin
    code = CODE_BLANK;
    dp   = 1'b0;
    if (disp.state == PAGE_WELCOME) begin
      code = CODE_DASH;
    end else if (disp.state <= PAGE_FAIL) begin
      case (idx)
        3'd7: if (blink_on) begin
                code = {1'b0, disp.state};
                dp   = 1'b1;
              end
        3'd1: if (two_digit)
                code = (val > 7'd99) ? CODE_DASH : 4'(val / 7'd10);
        3'd0: if (two_digit)
                code = (val > 7'd99) ? CODE_DASH : 4'(val % 7'd10);
              else
                code = (val > 7'd9) ? CODE_DASH : val[3:0];
        default: ;
      endcase
    end
  end

  seg7_decoder u_dec (
    .code (code),
    .dp   (dp),
    .seg  (seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div          <= '0;
      idx          <= '0;
      blink_cnt    <= '0;
      phase        <= 1'b1;
      state_q      <= '0;
      view_q       <= '0;
      disp.seg_en  <= 8'hFF;
      disp.seg_out <= 8'hFF;
    end else begin
      state_q <= disp.state;
      view_q  <= disp.view;
      div     <= tick ? '0 : div + 1'b1;
      if (tick) idx <= idx + 1'b1;

      if (restart) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (tick) begin
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      if (disp.view != 3'd0) begin
        disp.seg_en  <= 8'hFF;
        disp.seg_out <= 8'hFF;
      end else if (tick) begin
        disp.seg_en  <= ~(8'd1 << idx);
        disp.seg_out <= seg;
      end
    end
  end

endmodule

// File: tb/tb_setting_display.sv
module tb_setting_display;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  setting_display_if disp ();

  setting_display #(.SCAN_DIV(4), .BLINK_TICKS(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (disp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next scan tick's output update (negedge).
  task automatic next_tick();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_digit(input string tag, input int i, input logic [7:0] exp);
    logic [7:0] en;
    en = ~(8'd1 << i);
    chk({tag, "_en"}, disp.seg_en, en);
    chk(tag, disp.seg_out, exp);
  endtask

  logic [7:0] exp3 [8];

  initial begin
    exp3 = '{8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h30};
    rst = 1'b1;
    disp.view = 3'd0;           disp.state = 3'd3;
    disp.player_count = 3'd0;   disp.question_count = 4'd5;
    disp.answer_time = 7'd10;   disp.win_score = 7'd0;
    disp.success_score = 4'd0;  disp.fail_score = 4'd0;

    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("rst_en", disp.seg_en, 8'hFF);
      chk("rst_out", disp.seg_out, 8'hFF);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_first_en", disp.seg_en, 8'hFF);
    @(posedge clk); @(negedge clk);           // tick 1
    chk_digit("p3_d0", 0, exp3[0]);
    for (int i = 1; i < 8; i++) begin          // ticks 2..8
      next_tick();
      chk_digit("p3_scan", i, exp3[i]);
    end

    // Two-digit page overflow, then a value change mid-scan.
    disp.state = 3'd4; disp.win_score = 7'd120;
    next_tick(); chk_digit("p4_ovf_d0", 0, 8'hBF);   // tick 9
    next_tick(); chk_digit("p4_ovf_d1", 1, 8'hBF);   // tick 10
    disp.win_score = 7'd7;
    repeat (5) next_tick();                         // ticks 11..15
    next_tick(); chk_digit("p4_d7", 7, 8'h19);       // tick 16
    next_tick(); chk_digit("p4_d0", 0, 8'hF8);       // tick 17
    next_tick(); chk_digit("p4_d1", 1, 8'hC0);       // tick 18

    // Single-digit page; blink restarted by the page change.
    disp.state = 3'd1; disp.player_count = 3'd4;
    repeat (6) next_tick();                         // ticks 19..24
    next_tick(); chk_digit("p1_d0", 0, 8'h99);       // tick 25
    next_tick(); chk_digit("p1_d1", 1, 8'hFF);       // tick 26 (phase goes off)
    repeat (5) next_tick();                         // ticks 27..31
    next_tick(); chk_digit("blink_off", 7, 8'hFF);   // tick 32

    // Page change during the off phase forces the page digit back on.
    disp.state = 3'd2;
    next_tick(); chk_digit("p2_d0", 0, 8'h92);       // tick 33
    repeat (6) next_tick();                         // ticks 34..39
    next_tick(); chk_digit("blink_restart", 7, 8'h24); // tick 40

    disp.state = 3'd0;
    for (int i = 0; i < 8; i++) begin          // ticks 41..48
      next_tick();
      chk_digit("p0_dash", i, 8'hBF);
    end

    // Other view owns the display; page change here restarts the blink.
    disp.view = 3'd1; disp.state = 3'd5; disp.success_score = 4'd12;
    @(posedge clk); @(negedge clk);
    chk("view1_en", disp.seg_en, 8'hFF);
    chk("view1_out", disp.seg_out, 8'hFF);
    repeat (3) @(posedge clk);                      // tick 49
    @(negedge clk);
    chk("view1_tick_en", disp.seg_en, 8'hFF);
    chk("view1_tick_out", disp.seg_out, 8'hFF);
    repeat (9) next_tick();                         // ticks 50..58 (phase off at 56)
    chk("view1_late_en", disp.seg_en, 8'hFF);
    disp.view = 3'd0;
    repeat (5) next_tick();                         // ticks 59..63
    next_tick(); chk_digit("view0_d7", 7, 8'h12);    // tick 64
    next_tick(); chk_digit("p5_ovf_d0", 0, 8'hBF);   // tick 65
    next_tick(); chk_digit("p5_d1", 1, 8'hFF);       // tick 66

    disp.state = 3'd7;
    repeat (4) next_tick();                         // ticks 67..70
    next_tick(); chk_digit("p7_d6", 6, 8'hFF);       // tick 71
    next_tick(); chk_digit("p7_d7", 7, 8'hFF);       // tick 72
    next_tick(); chk_digit("p7_d0", 0, 8'hFF);       // tick 73

    // Reset with the scan index at 5.
    disp.state = 3'd5;
    repeat (3) next_tick();                         // ticks 74..76
    next_tick(); chk_digit("pre_rst_d4", 4, 8'hFF);  // tick 77
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_en", disp.seg_en, 8'hFF);
    chk("mid_rst_out", disp.seg_out, 8'hFF);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_wait_en", disp.seg_en, 8'hFF);
    @(posedge clk); @(negedge clk);
    chk_digit("post_rst_d0", 0, 8'hBF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
